// File: rtl/cacheline_arbiter_pkg.sv
// Shared types for the I/D cacheline arbiter.
//   arb_state_t      : arbiter FSM states
//   arb_grant_t      : which client owns the memory port
//   LINE_OFFSET_BITS : byte-offset bits of a 32-byte line, cleared on pmem_address
//   pick_grant()     : tie resolution between pending I and D requests
package arbiter_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } arb_grant_t;

  localparam int LINE_OFFSET_BITS = 5;

  // D wins unless I is also pending and currently holds priority.
  function automatic arb_grant_t pick_grant(input logic i_req, input logic d_req,
                                            input logic prefer_i);
    if (d_req && !(i_req && prefer_i)) return GRANT_D;
    return GRANT_I;
  endfunction

endpackage

// File: rtl/cacheline_arbiter_if.sv
// Bus bundle between the two cache clients, the arbiter and physical memory.
//   slave  : arbiter view (client requests and memory response in, client
//            responses and memory request out)
//   master : environment view (caches + memory model), the mirror image
interface cacheline_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);

  // I-cache client
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic              i_resp;
  logic [LINE_W-1:0] i_rdata;
  // D-cache client
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic              d_resp;
  logic [LINE_W-1:0] d_rdata;
  // physical memory port
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic              pmem_resp;
  logic [LINE_W-1:0] pmem_rdata;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_resp, pmem_rdata,
    output i_resp, i_rdata, d_resp, d_rdata,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_resp, pmem_rdata,
    input  i_resp, i_rdata, d_resp, d_rdata,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );

endinterface

// File: rtl/cacheline_arbiter_mux.sv
// arbiter_mux: combinational datapath of the cacheline arbiter.
// Steers the granted client's request, line-aligned address and write data to
// the memory port, and routes pmem_resp / pmem_rdata back to that client only.
//   sel_i / sel_d : one-hot "currently serving" selects from the FSM
//   i_* / d_*     : client request side and per-client response outputs
//   pmem_*        : memory port
// With neither select set every output is 0.
module arbiter_mux
  import arbiter_types::*;
#(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              sel_i,
  input  logic              sel_d,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata
);

  logic [ADDR_W-1:0] i_line_addr, d_line_addr;

  assign i_line_addr = {i_address[ADDR_W-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
  assign d_line_addr = {d_address[ADDR_W-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};

  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_resp       = 1'b0;
    i_rdata      = '0;
    d_resp       = 1'b0;
    d_rdata      = '0;
    if (sel_i) begin
      pmem_read    = i_read;
      pmem_address = i_line_addr;
      i_resp       = pmem_resp;
      i_rdata      = pmem_rdata;
    end else if (sel_d) begin
      // a write-back wins if a misbehaving client raises both strobes
      pmem_write   = d_write;
      pmem_read    = d_read & ~d_write;
      pmem_address = d_line_addr;
      pmem_wdata   = d_wdata;
      d_resp       = pmem_resp;
      d_rdata      = pmem_rdata;
    end
  end

endmodule

// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter: shares one physical memory port between the I-cache and
// the D-cache. One line transaction at a time; a RELEASE cycle follows every
// completion so memory can retire its handshake before the next request.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : cacheline_arbiter_if.slave (client requests/responses, pmem port)
// Build option ARB_ROUND_ROBIN_EN: when defined, a 1-bit pointer alternates
// priority on simultaneous requests; otherwise the D-cache always wins ties.
module cacheline_arbiter
  import arbiter_types::*;
#(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  cacheline_arbiter_if.slave  bus
);

  arb_state_t state, state_nxt;
  arb_grant_t grant;
  logic       i_req, d_req;
  logic       prefer_i;
  logic       sel_i, sel_d;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;
  assign grant = pick_grant(i_req, d_req, prefer_i);

`ifdef ARB_ROUND_ROBIN_EN
  // Pointer flips toward the client that was not just granted; it only
  // moves on a grant, so idle cycles never disturb the rotation.
  always_ff @(posedge clk) begin
    if (rst)
      prefer_i <= 1'b0;
    else if (state == IDLE && (i_req | d_req))
      prefer_i <= (grant == GRANT_D);
  end
`else
  assign prefer_i = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state; the serve states wait for pmem_resp even if the client
  // withdraws its request, so memory is never abandoned mid-transaction
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_req | d_req) state_nxt = (grant == GRANT_D) ? SERVE_D : SERVE_I;
      SERVE_I,
      SERVE_D: if (bus.pmem_resp) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs: the datapath only needs to know who is being served
  always_comb begin
    sel_i = (state == SERVE_I);
    sel_d = (state == SERVE_D);
  end

  arbiter_mux #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) u_mux (
    .sel_i        (sel_i),
    .sel_d        (sel_d),
    .i_read       (bus.i_read),
    .i_address    (bus.i_address),
    .d_read       (bus.d_read),
    .d_write      (bus.d_write),
    .d_address    (bus.d_address),
    .d_wdata      (bus.d_wdata),
    .pmem_resp    (bus.pmem_resp),
    .pmem_rdata   (bus.pmem_rdata),
    .i_resp       (bus.i_resp),
    .i_rdata      (bus.i_rdata),
    .d_resp       (bus.d_resp),
    .d_rdata      (bus.d_rdata),
    .pmem_read    (bus.pmem_read),
    .pmem_write   (bus.pmem_write),
    .pmem_address (bus.pmem_address),
    .pmem_wdata   (bus.pmem_wdata)
  );

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Self-checking bench for cacheline_arbiter: directed scenarios with literal
// expectations, then randomized client/memory traffic checked every cycle
// against a transaction-level model (owner / release flag / priority bit).
module tb_cacheline_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cacheline_arbiter_if #(.LINE_W(LW), .ADDR_W(AW)) bus ();
  cacheline_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- reference model ----------------
  // owner: 0 nobody, 1 I-cache, 2 D-cache. rel: one idle cycle owed after a
  // completion. pref_i: I wins the next tie (round-robin build only).
  int m_owner  = 0;
  bit m_rel    = 1'b0;
  bit m_pref_i = 1'b0;
  bit chk_en   = 1'b0;

  always @(negedge clk) begin : model
    logic          e_rd, e_wr, e_ir, e_dr, ireq, dreq;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_wd;
    if (chk_en) begin
      e_rd = 1'b0; e_wr = 1'b0; e_ir = 1'b0; e_dr = 1'b0;
      e_addr = '0; e_wd = '0;
      if (m_owner == 1) begin
        e_rd   = bus.i_read;
        e_addr = bus.i_address & ~32'h1f;
        e_ir   = bus.pmem_resp;
      end else if (m_owner == 2) begin
        e_wr   = bus.d_write;
        e_rd   = bus.d_read && !bus.d_write;
        e_addr = bus.d_address & ~32'h1f;
        e_wd   = bus.d_wdata;
        e_dr   = bus.pmem_resp;
      end
      chk("pmem_read",    LW'(bus.pmem_read),    LW'(e_rd));
      chk("pmem_write",   LW'(bus.pmem_write),   LW'(e_wr));
      chk("pmem_address", LW'(bus.pmem_address), LW'(e_addr));
      if (m_owner != 1) chk("pmem_wdata", bus.pmem_wdata, e_wd);
      chk("i_resp", LW'(bus.i_resp), LW'(e_ir));
      chk("d_resp", LW'(bus.d_resp), LW'(e_dr));
      // the served client's rdata only has meaning while resp is up
      if (m_owner != 1 || bus.pmem_resp) chk("i_rdata", bus.i_rdata, e_ir ? bus.pmem_rdata : '0);
      if (m_owner != 2 || bus.pmem_resp) chk("d_rdata", bus.d_rdata, e_dr ? bus.pmem_rdata : '0);
    end
    ireq = bus.i_read;
    dreq = bus.d_read || bus.d_write;
    if (rst) begin
      m_owner = 0; m_rel = 1'b0; m_pref_i = 1'b0;
    end else if (m_owner != 0) begin
      if (bus.pmem_resp) begin m_owner = 0; m_rel = 1'b1; end
    end else if (m_rel) begin
      m_rel = 1'b0;
    end else if (ireq || dreq) begin
`ifdef ARB_ROUND_ROBIN_EN
      m_owner  = (dreq && !(ireq && m_pref_i)) ? 2 : 1;
      m_pref_i = (m_owner == 2);
`else
      m_owner  = dreq ? 2 : 1;
`endif
    end
  end

  // ---------------- environment: clients + memory ----------------
  bit            auto_mode = 1'b0;
  bit            inject    = 1'b0;
  int            mem_lat   = 3;
  int            mem_cnt   = 0;
  int            cyc       = 0;
  int            i_left = 0, d_left = 0, i_cnt = 0, d_cnt = 0;
  int            order = 0, resp_cyc = 0, zero_run = 0, n_gaps = 0;
  int            gaps [8];
  bit            saw_i, saw_d;
  logic [AW-1:0] s_i_addr = '0, s_d_addr = '0;
  logic          s_d_wr = 1'b0;
  logic [LW-1:0] s_d_wdata = '0;
  // snapshot of DUT outputs at the last negedge
  logic          s_rd, s_wr, s_ir, s_dr;
  logic [AW-1:0] s_addr;
  logic [LW-1:0] s_wd, s_irdata, got_i_rdata, sent_rdata;

  task automatic drive_clients();
    int k;
    if (auto_mode) begin
      if (bus.i_read) begin
        if (saw_i) begin
          if ($urandom % 4 == 0) bus.i_address = $urandom;
          else bus.i_read = 1'b0;
        end
      end else if ($urandom % 3 == 0) begin
        bus.i_read = 1'b1; bus.i_address = $urandom;
      end
      if ((bus.d_read || bus.d_write) && !saw_d) begin
        // hold the outstanding request unchanged
      end else if ((bus.d_read || bus.d_write) && $urandom % 4 != 0) begin
        bus.d_read = 1'b0; bus.d_write = 1'b0;
      end else if (saw_d || $urandom % 3 == 0) begin
        k = $urandom % 16;
        bus.d_read    = (k == 0) || (k >= 7);
        bus.d_write   = (k < 7);
        bus.d_address = $urandom;
        bus.d_wdata   = rand_line();
      end
    end else begin
      bus.i_read    = (i_left > 0);
      bus.i_address = s_i_addr;
      bus.d_read    = (d_left > 0) && !s_d_wr;
      bus.d_write   = (d_left > 0) && s_d_wr;
      bus.d_address = s_d_addr;
      bus.d_wdata   = s_d_wdata;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (mem_cnt == 0 && (bus.pmem_read || bus.pmem_write) && !bus.pmem_resp)
      mem_cnt = auto_mode ? $urandom_range(1, 6) : mem_lat;
    s_rd = bus.pmem_read; s_wr = bus.pmem_write; s_addr = bus.pmem_address;
    s_wd = bus.pmem_wdata; s_ir = bus.i_resp; s_dr = bus.d_resp; s_irdata = bus.i_rdata;
    if (!bus.pmem_read && !bus.pmem_write) zero_run++;
    saw_i = bus.i_resp;
    saw_d = bus.d_resp;
    if (bus.i_resp || bus.d_resp) begin
      resp_cyc = cyc;
      if (n_gaps < 8) gaps[n_gaps] = zero_run;
      n_gaps++;
      zero_run = 0;
    end
    if (bus.i_resp) begin
      i_cnt++; order = order * 4 + 1;
      if (i_left > 0) i_left--;
      got_i_rdata = bus.i_rdata; sent_rdata = bus.pmem_rdata;
    end
    if (bus.d_resp) begin
      d_cnt++; order = order * 4 + 2;
      if (d_left > 0) d_left--;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (mem_cnt == 1) begin
      bus.pmem_resp = 1'b1; mem_cnt = 0;
    end else begin
      bus.pmem_resp = inject;
      if (mem_cnt > 1) mem_cnt--;
    end
    inject = 1'b0;
    if (auto_mode && m_owner == 0 && $urandom % 10 == 0) bus.pmem_resp = 1'b1;
    bus.pmem_rdata = rand_line();
    if (auto_mode) rst = ($urandom % 700 == 0);
    drive_clients();
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0; tick();
  endtask

  initial begin
    bus.i_read = 0; bus.i_address = '0; bus.d_read = 0; bus.d_write = 0;
    bus.d_address = '0; bus.d_wdata = '0; bus.pmem_resp = 0; bus.pmem_rdata = rand_line();
    tick();
    chk_en = 1'b1;
    tick();
    chk("reset_pmem_read",  LW'(s_rd), '0);
    chk("reset_pmem_write", LW'(s_wr), '0);
    chk("reset_pmem_addr",  LW'(s_addr), '0);
    chk("reset_i_resp",     LW'(s_ir), '0);
    chk("reset_d_resp",     LW'(s_dr), '0);
    chk("reset_i_rdata",    s_irdata, '0);
    rst = 1'b0; tick();

    // 1) single I read of 0x60, memory latency 5
    mem_lat = 5; i_cnt = 0; d_cnt = 0;
    s_i_addr = 32'h0000_0060; i_left = 1; drive_clients();
    resp_cyc = cyc;
    tick(); chk("t1_grant_cycle_read", LW'(s_rd), '0);
    tick(); chk("t1_pmem_addr", LW'(s_addr), LW'(32'h0000_0060));
    chk("t1_pmem_read", LW'(s_rd), LW'(1'b1));
    for (int k = 0; k < 40 && i_cnt < 1; k++) tick();
    chk("t1_resp_cycle", LW'(resp_cyc - (cyc - 1 - 0) + 6), LW'(6));
    chk("t1_i_rdata", got_i_rdata, sent_rdata);
    tick(); chk("t1_release_read", LW'(s_rd), '0);
    chk("t1_release_write", LW'(s_wr), '0);
    repeat (5) tick();
    chk("t1_i_resp_count", LW'(i_cnt), LW'(1));
    chk("t1_d_resp_count", LW'(d_cnt), '0);

    // 2) D write-back to 0x1234
    mem_lat = 3; i_cnt = 0; d_cnt = 0;
    s_d_addr = 32'h0000_1234; s_d_wr = 1'b1; s_d_wdata = {8{32'hDEADBEEF}};
    d_left = 1; drive_clients();
    tick(); tick();
    chk("t2_pmem_addr",  LW'(s_addr), LW'(32'h0000_1220));
    chk("t2_pmem_write", LW'(s_wr), LW'(1'b1));
    chk("t2_pmem_read",  LW'(s_rd), '0);
    chk("t2_pmem_wdata", s_wd, {8{32'hDEADBEEF}});
    for (int k = 0; k < 40 && d_cnt < 1; k++) tick();
    repeat (5) tick();
    chk("t2_d_resp_count", LW'(d_cnt), LW'(1));
    chk("t2_i_resp_count", LW'(i_cnt), '0);

    // 3) simultaneous I and D reads from reset, each client asking 3 times
    do_reset();
    mem_lat = 2; s_d_wr = 1'b0; s_d_addr = 32'h2000; s_i_addr = 32'h3000;
    order = 0; i_left = 3; d_left = 3; drive_clients();
    for (int k = 0; k < 200 && (i_left > 0 || d_left > 0); k++) tick();
    repeat (4) tick();
`ifdef ARB_ROUND_ROBIN_EN
    chk("t3_grant_order", LW'(order), LW'(32'h999));  // D I D I D I
`else
    chk("t3_grant_order", LW'(order), LW'(32'hA95));  // D D D I I I
`endif

    // 4) back-to-back D reads, request held straight through resp
    mem_lat = 3; d_cnt = 0; n_gaps = 0; zero_run = 0; s_d_addr = 32'h4400;
    d_left = 3; drive_clients();
    for (int k = 0; k < 100 && d_left > 0; k++) tick();
    repeat (6) tick();
    // request-free cycles between completions: RELEASE plus the IDLE grant cycle
    chk("t4_gap_1", LW'(gaps[1]), LW'(2));
    chk("t4_gap_2", LW'(gaps[2]), LW'(2));
    chk("t4_d_resp_count", LW'(d_cnt), LW'(3));

    // 5) reset two cycles into SERVE_D, then a stray completion arrives
    mem_lat = 8; i_cnt = 0; d_cnt = 0; s_d_addr = 32'h0000_0040;
    d_left = 1; drive_clients();
    tick(); tick(); tick();
    rst = 1'b1; d_left = 0; drive_clients();
    tick();
    rst = 1'b0;
    tick();
    chk("t5_pmem_read",  LW'(s_rd), '0);
    chk("t5_pmem_write", LW'(s_wr), '0);
    chk("t5_pmem_addr",  LW'(s_addr), '0);
    repeat (12) tick();
    chk("t5_no_d_resp", LW'(d_cnt), '0);
    chk("t5_no_i_resp", LW'(i_cnt), '0);

    // 6) pmem_resp while IDLE
    bus.pmem_resp = 1'b1;
    tick();
    chk("t6_i_resp", LW'(s_ir), '0);
    chk("t6_d_resp", LW'(s_dr), '0);
    tick();
    chk("t6_still_idle", LW'(s_rd), '0);

    // 7) randomized traffic, occasional resets and stray completions
    do_reset();
    auto_mode = 1'b1;
    repeat (4000) tick();
    auto_mode = 1'b0; rst = 1'b0; i_left = 0; d_left = 0; drive_clients();
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cacheline_arbiter.md
# cacheline_arbiter

Two-client cacheline arbiter between the instruction cache and the data cache, upstream of the single physical memory port. It picks one pending 256-bit line transaction, routes it to memory, returns the memory response to that client only, and inserts one idle release cycle after each transaction so the memory finishes its response handshake before the next request is presented.

## Interface
Parameters:
- `LINE_W`, 256, cacheline width in bits.
- `ADDR_W`, 32, byte address width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_read`  in  1  I-cache line read request (no I-cache write port).
- `i_address`  in  ADDR_W  I-cache line address.
- `i_resp`  out  1  I-cache transaction complete.
- `i_rdata`  out  LINE_W  I-cache read line.
- `d_read` / `d_write`  in  1 each  D-cache read / write-back request.
- `d_address`  in  ADDR_W  D-cache line address.
- `d_wdata`  in  LINE_W  D-cache write-back line.
- `d_resp`  out  1  D-cache transaction complete.
- `d_rdata`  out  LINE_W  D-cache read line.
- `pmem_read` / `pmem_write`  out  1 each  memory request.
- `pmem_address`  out  ADDR_W  memory address, bits [4:0] forced to 0.
- `pmem_wdata`  out  LINE_W  memory write line.
- `pmem_resp`  in  1  memory completion, one-cycle pulse.
- `pmem_rdata`  in  LINE_W  memory read line, valid while `pmem_resp` is high.

## Operation
- States: IDLE, SERVE_I, SERVE_D, RELEASE.
- IDLE: no pmem request. If any request is pending, latch the grant and go to SERVE_I or SERVE_D on the next edge.
- SERVE_x: the granted client's read/write/address/wdata pass combinationally to pmem. The other client sees resp=0.
- When `pmem_resp` is high in SERVE_x, the granted `x_resp` is high in the same cycle and `x_rdata` = `pmem_rdata`. The state then goes to RELEASE.
- RELEASE: all pmem requests are low for exactly one cycle, then the state returns to IDLE.
- `d_read` and `d_write` are never both high. If they are, the write wins.
- Clients hold their request and inputs stable until they see resp. They deassert resp the cycle after.
- If the granted client drops its request during SERVE_x, which is a protocol violation, the arbiter stays in SERVE_x until `pmem_resp`.
- Unselected `x_rdata` outputs are driven to 0.

## Timing
- Reset values: state IDLE, all pmem outputs 0, `i_resp` = `d_resp` = 0, rdata outputs 0, round-robin pointer set to D-first.
- Request-to-pmem latency: 1 cycle (IDLE → SERVE).
- Back-to-back throughput: each transaction costs the memory latency plus 2 cycles (grant cycle and RELEASE cycle).
- Simultaneous I and D requests in IDLE are resolved by the configured policy (see Configuration).
- Reset during SERVE or RELEASE: return to IDLE, all pmem requests drop. Any in-flight memory completion after reset is ignored; resp is not forwarded.
- A `pmem_resp` seen in IDLE or RELEASE is ignored.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - A 1-bit pointer alternates priority on simultaneous requests.
  - After serving D, I has priority, and vice versa.
  - The pointer updates only when a grant is made.
- `ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority, D-cache always wins ties.
  - No pointer register exists.

## Structure
- Shared package `arbiter_types`:
  - state enum `arb_state_t` {IDLE, SERVE_I, SERVE_D, RELEASE}.
  - grant enum `arb_grant_t` {GRANT_I, GRANT_D}.
  - `LINE_OFFSET_BITS` = 5.
- One sub-module is natural: `arbiter_mux`. It is the combinational datapath that steers client request, address and wdata to pmem and pmem_rdata to the granted client.
- The FSM and pointer stay in the top module.

## Test plan
- Single I read of 0x0000_0060, memory latency 5 cycles:
  - `pmem_address` = 0x0000_0060 from cycle 1.
  - `i_resp` pulses once with `pmem_rdata`.
  - `d_resp` stays 0.
  - `pmem_read` is low in the RELEASE cycle.
- D write-back to 0x0000_1234 with wdata = {8{32'hDEADBEEF}}:
  - `pmem_address` = 0x0000_1220.
  - `pmem_write` = 1 and `pmem_wdata` matches.
  - `d_resp` pulses once.
- Simultaneous I read and D read from reset:
  - Without the macro: D is served first, then I; D wins every tie across 3 repeated contentions.
  - With the macro: D, then I, then alternating on repeated contention.
- Back-to-back D reads with the request held high immediately after resp:
  - Exactly one RELEASE cycle with both pmem requests 0 between transactions.
  - No duplicate resp.
- `rst` asserted 2 cycles into SERVE_D:
  - Next cycle: IDLE, pmem outputs 0.
  - A later stray `pmem_resp` produces no client resp.
- `pmem_resp` injected while in IDLE: no client resp, state unchanged.
